// File: rtl/aes_pkg.sv
// Shared AES definitions: key-length codes, round counts, controller states
// and the GF(2^8) helpers used by the round datapath.
package aes_pkg;

    localparam logic       AES_128_BIT_KEY = 1'b0;
    localparam logic       AES_256_BIT_KEY = 1'b1;
    localparam logic [3:0] AES128_ROUNDS   = 4'd10;
    localparam logic [3:0] AES256_ROUNDS   = 4'd14;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        INIT  = 3'd1,
        SBOX  = 3'd2,
        MAIN  = 3'd3,
        FINAL = 3'd4
    } aes_state_t;

    // Forward S-box, entry 0 in the top byte.
    localparam logic [2047:0] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    // Top bit of entry b sits at 2047 - 8*b, which is {~b, 3'b111}.
    function automatic logic [7:0] sbox_lookup(input logic [7:0] b);
        return SBOX_TABLE[{~b, 3'b111} -: 8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // One MixColumns column, {02,03,01,01} circulant; byte 0 is bits 31:24.
    function automatic logic [31:0] mixw(input logic [31:0] w);
        logic [7:0] b0, b1, b2, b3;
        b0 = w[31:24];
        b1 = w[23:16];
        b2 = w[15:8];
        b3 = w[7:0];
        return {xtime(b0) ^ xtime(b1) ^ b1 ^ b2 ^ b3,
                b0 ^ xtime(b1) ^ xtime(b2) ^ b2 ^ b3,
                b0 ^ b1 ^ xtime(b2) ^ xtime(b3) ^ b3,
                xtime(b0) ^ b0 ^ b1 ^ b2 ^ xtime(b3)};
    endfunction

    function automatic logic [127:0] mixcolumns(input logic [127:0] s);
        return {mixw(s[127:96]), mixw(s[95:64]), mixw(s[63:32]), mixw(s[31:0])};
    endfunction

    // Column-major state: state byte n lives in s[15-n]; row r rotates left by r.
    function automatic logic [127:0] shiftrows(input logic [15:0][7:0] s);
        return {s[15], s[10], s[5],  s[0],
                s[11], s[6],  s[1],  s[12],
                s[7],  s[2],  s[13], s[8],
                s[3],  s[14], s[9],  s[4]};
    endfunction

endpackage

// File: rtl/aes_encipher_block_if.sv
// Request/response bundle between the key memory, the requester and the
// encipher datapath.
interface aes_encipher_block_if;
    logic         next;
    logic         keylen;
    logic [3:0]   round;
    logic [127:0] round_key;
    logic [127:0] block;
    logic [127:0] new_block;
    logic         ready;

    modport master (
        output next, keylen, block, round_key,
        input  round, new_block, ready
    );

    modport slave (
        input  next, keylen, block, round_key,
        output round, new_block, ready
    );
endinterface

// File: rtl/aes_sbox.sv
// Single-byte forward AES S-box, purely combinational.
module aes_sbox
    import aes_pkg::*;
(
    input  logic [7:0] i_in,
    output logic [7:0] o_out
);
    assign o_out = sbox_lookup(i_in);
endmodule

// File: rtl/aes_encipher_block.sv
// Iterative AES-128/256 encipher round engine. SubBytes is done one 32-bit
// word per cycle through four byte S-boxes; ShiftRows, MixColumns and
// AddRoundKey complete each round in a single cycle.
module aes_encipher_block
    import aes_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    aes_encipher_block_if.slave  bus
);
    aes_state_t   r_fsm, w_fsm_next;
    logic [127:0] r_block, w_block_next;
    logic [3:0]   r_round, w_round_next;
    logic [3:0]   r_nr, w_nr_next;
    logic [1:0]   r_word_ctr, w_word_ctr_next;
    logic         r_ready, w_ready_next;

    logic [31:0]  w_sbox_in;
    logic [31:0]  w_sbox_out;
    logic [127:0] w_sub_block;

    // Word k occupies bits (3-k)*32 +: 32, i.e. base {~k, 5'b0}.
    assign w_sbox_in = r_block[{~r_word_ctr, 5'b0} +: 32];

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_sbox
            aes_sbox u_sbox (
                .i_in  (w_sbox_in[8*gi +: 8]),
                .o_out (w_sbox_out[8*gi +: 8])
            );
        end
    endgenerate

    // Write the substituted word back into its slot of the state.
    always_comb begin
        w_sub_block = r_block;
        w_sub_block[{~r_word_ctr, 5'b0} +: 32] = w_sbox_out;
    end

    // Controller and datapath next-state: one case per FSM state.
    always_comb begin
        w_fsm_next      = r_fsm;
        w_block_next    = r_block;
        w_round_next    = r_round;
        w_nr_next       = r_nr;
        w_word_ctr_next = r_word_ctr;
        w_ready_next    = r_ready;
        case (r_fsm)
            IDLE: begin
                if (bus.next) begin
                    w_block_next = bus.block;
                    w_nr_next    = (bus.keylen == AES_256_BIT_KEY) ? AES256_ROUNDS : AES128_ROUNDS;
                    w_round_next = 4'd0;
                    w_ready_next = 1'b0;
                    w_fsm_next   = INIT;
                end
            end
            INIT: begin
                w_block_next    = r_block ^ bus.round_key;
                w_round_next    = 4'd1;
                w_word_ctr_next = 2'd0;
                w_fsm_next      = SBOX;
            end
            SBOX: begin
                w_block_next    = w_sub_block;
                w_word_ctr_next = r_word_ctr + 2'd1;
                if (r_word_ctr == 2'd3) begin
                    w_fsm_next = (r_round < r_nr) ? MAIN : FINAL;
                end
            end
            MAIN: begin
                w_block_next = mixcolumns(shiftrows(r_block)) ^ bus.round_key;
                w_round_next = r_round + 4'd1;
                w_fsm_next   = SBOX;
            end
            FINAL: begin
                w_block_next = shiftrows(r_block) ^ bus.round_key;
                w_round_next = 4'd0;
                w_ready_next = 1'b1;
                w_fsm_next   = IDLE;
            end
            default: begin
                w_fsm_next = IDLE;
            end
        endcase
    end

    // State register; reset abandons any operation in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_fsm      <= IDLE;
            r_block    <= '0;
            r_round    <= 4'd0;
            r_nr       <= AES128_ROUNDS;
            r_word_ctr <= 2'd0;
            r_ready    <= 1'b1;
        end else begin
            r_fsm      <= w_fsm_next;
            r_block    <= w_block_next;
            r_round    <= w_round_next;
            r_nr       <= w_nr_next;
            r_word_ctr <= w_word_ctr_next;
            r_ready    <= w_ready_next;
        end
    end

    assign bus.round     = r_round;
    assign bus.ready     = r_ready;
    assign bus.new_block = r_block;

endmodule
